pipe_hazard_unit: RTL
=====================

Name: pipe_hazard_unit

Overview:
- Parametrised scoreboard and forwarding controller for the CPU pipeline; sits between the decode stage and the execute stage.
- Tracks the destination register of every in-flight instruction across DEPTH post-decode stages (index 0 = EX, DEPTH-1 = WB).
- Detects read-after-write hazards and generates registered forwarding selects for the EX operand muxes.
- Stalls decode and injects bubbles when a result cannot be forwarded in time (load-use, long-latency producers).

Parameters:
- REG_BITS, 5, width of register specifiers.
- DEPTH, 3, number of tracked stages after decode; legal range 2..8.
- LOAD_READY, 2, first stage index at which load data is forwardable; must be 1..DEPTH-1.
- ALU_READY, 1, first stage index at which ALU/MUL results are forwardable; must be 1..LOAD_READY.
- SELW, 3, width of forwarding selects; must satisfy 2^SELW > DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  decode holds a real instruction.
- id_a_reg  in  REG_BITS  source A specifier.
- id_b_reg  in  REG_BITS  source B specifier.
- id_uses_a  in  1  source A is read.
- id_uses_b  in  1  source B is read.
- id_wb_en  in  1  instruction writes a register.
- id_wb_reg  in  REG_BITS  destination specifier.
- id_is_load  in  1  instruction is a memory load.
- flush  in  1  discard the decode instruction this cycle.
- stall  out  1  combinational; hold PC and decode registers.
- ex_valid  out  1  registered; EX holds a real instruction.
- fwd_a_sel  out  SELW  registered; EX operand A source: 0 = register file, k = result of stage k (1..DEPTH-1).
- fwd_b_sel  out  SELW  registered; same encoding for operand B.

Behaviour:
- Scoreboard: DEPTH entries {valid, wb_en, wb_reg, is_load}. Every clock, entry i moves to entry i+1 and entry DEPTH-1 retires. Entries never stall; only decode stalls.
- Entry 0 is loaded with the decode instruction when id_valid & !stall & !flush. Otherwise entry 0 becomes a bubble (valid=0).
- Producer match for a source reg r (checked only when id_uses_x=1): entry k with valid & wb_en & wb_reg==r & r!=0. The youngest match (lowest k) wins.
- On the next cycle the producer sits at stage p=k+1 while the consumer is in EX. Let ready = LOAD_READY if is_load, else ALU_READY.
  - p <= DEPTH-1 and p >= ready: forward; select = p.
  - p <= DEPTH-1 and p < ready: hazard.
  - p > DEPTH-1 (producer retires this cycle): the register file write-through supplies the value; select = 0.
- No match, or r==0: select = 0.
- stall = id_valid & !flush & (hazard on A or hazard on B). stall is combinational from inputs and scoreboard state.
- fwd_a_sel, fwd_b_sel and ex_valid are registered on the same edge that loads entry 0. They are forced to 0 whenever entry 0 is loaded as a bubble.
- Repeated stalls: a stalled instruction is re-evaluated every cycle. For LOAD_READY=2 a dependent load-use costs exactly 1 stall cycle. Two back-to-back loads followed by a consumer of the first load cost 0 stalls.
- Simultaneous flush and stall: flush wins; stall=0 and a bubble is inserted.
- id_wb_en=1 with id_wb_reg=0 is tracked but never matches.
- Reset (asynchronous, mid-operation included): all entries valid=0; ex_valid=0; fwd_a_sel=fwd_b_sel=0. stall is then 0 because no entry is valid.
- Parameter checks: illegal parameter values trigger an elaboration-time error through a generate guard.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds output stall_cnt (32 bits). It increments on every cycle with stall=1, saturates at 0xFFFFFFFF, and resets to 0.
- When undefined, the port and counter are absent.

Test Plan:
- ALU dependence: `add r3` then `sub r4,r3,r3` -> stall=0 throughout; the next cycle has ex_valid=1, fwd_a_sel=fwd_b_sel=1.
- Load-use (LOAD_READY=2): `lw r5` then `add r6,r5,r1` -> stall=1 for exactly 1 cycle; the add enters EX with fwd_a_sel=2, fwd_b_sel=0; the bubble cycle shows ex_valid=0.
- Register zero: a producer writes r0, then the consumer reads r0 -> stall=0, selects 0.
- Youngest wins: `add r2`, `or r2`, then a consumer of r2 -> fwd_a_sel=1, not 2. With DEPTH=3 and a producer 3 instructions earlier -> select 0, no stall.
- Flush during stall: drive the load-use case and assert flush in the stall cycle -> stall=0 that cycle, ex_valid=0 on the next cycle, scoreboard entry 0 invalid.
- Async reset mid-stream: assert rst between clock edges with 3 valid entries -> ex_valid and selects go to 0 immediately; the first post-reset consumer sees no hazard. With HAZARD_STATS_EN, stall_cnt reads 0.

Source files
------------

// File: rtl/pipe_hazard_if.sv
// Decode <-> hazard-unit bundle: decode-stage instruction fields in, stall and
// registered EX forwarding controls out.
interface pipe_hazard_if #(
  parameter int REG_BITS = 5,
  parameter int SELW     = 3
);
  logic                id_valid;
  logic [REG_BITS-1:0] id_a_reg;
  logic [REG_BITS-1:0] id_b_reg;
  logic                id_uses_a;
  logic                id_uses_b;
  logic                id_wb_en;
  logic [REG_BITS-1:0] id_wb_reg;
  logic                id_is_load;
  logic                flush;
  logic                stall;
  logic                ex_valid;
  logic [SELW-1:0]     fwd_a_sel;
  logic [SELW-1:0]     fwd_b_sel;

  modport master (
    output id_valid, id_a_reg, id_b_reg, id_uses_a, id_uses_b,
           id_wb_en, id_wb_reg, id_is_load, flush,
    input  stall, ex_valid, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  id_valid, id_a_reg, id_b_reg, id_uses_a, id_uses_b,
           id_wb_en, id_wb_reg, id_is_load, flush,
    output stall, ex_valid, fwd_a_sel, fwd_b_sel
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Scoreboard + forwarding controller between decode and EX; stalls decode on
// load-use / slow producers. Optional stall counter behind HAZARD_STATS_EN.
module pipe_hazard_unit #(
  parameter int REG_BITS   = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int ALU_READY  = 1,
  parameter int SELW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  pipe_hazard_if.slave  bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  generate
    if (DEPTH < 2 || DEPTH > 8 ||
        LOAD_READY < 1 || LOAD_READY > DEPTH - 1 ||
        ALU_READY < 1 || ALU_READY > LOAD_READY ||
        (1 << SELW) <= DEPTH) begin : g_bad_params
      $error("pipe_hazard_unit: illegal parameter combination");
    end
  endgenerate

  typedef struct packed {
    logic            hazard;
    logic [SELW-1:0] sel;
  } fwd_t;

  // Scoreboard, index 0 = EX ... DEPTH-1 = WB.
  logic [DEPTH-1:0]               sb_valid;
  logic [DEPTH-1:0]               sb_wb_en;
  logic [DEPTH-1:0]               sb_load;
  logic [DEPTH-1:0][REG_BITS-1:0] sb_reg;

  fwd_t res_a;
  fwd_t res_b;
  logic load;

  // Scanning oldest-to-youngest lets the youngest matching producer win.
  function automatic fwd_t resolve(
    input logic                           use_r,
    input logic [REG_BITS-1:0]            r,
    input logic [DEPTH-1:0]               v,
    input logic [DEPTH-1:0]               we,
    input logic [DEPTH-1:0]               ld,
    input logic [DEPTH-1:0][REG_BITS-1:0] regs
  );
    fwd_t res;
    res = '0;
    if (use_r && r != '0) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (v[k] && we[k] && regs[k] == r) begin
          res = '0;
          if (k + 1 <= DEPTH - 1) begin
            if (k + 1 >= (ld[k] ? LOAD_READY : ALU_READY))
              res.sel = SELW'(k + 1);
            else
              res.hazard = 1'b1;
          end
        end
      end
    end
    return res;
  endfunction

  // NOTE: every always_comb output gets a value on every path (here via
  // the function's own default), so no latch can be inferred.
  always_comb begin
    res_a = resolve(bus.id_uses_a, bus.id_a_reg, sb_valid, sb_wb_en, sb_load, sb_reg);
    res_b = resolve(bus.id_uses_b, bus.id_b_reg, sb_valid, sb_wb_en, sb_load, sb_reg);
  end

  assign bus.stall = bus.id_valid & ~bus.flush & (res_a.hazard | res_b.hazard);
  assign load      = bus.id_valid & ~bus.stall & ~bus.flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the whole scoreboard is reset (not just valid)
  // because it is a handful of flops, not a RAM, and this keeps it X-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_valid      <= '0;
      sb_wb_en      <= '0;
      sb_load       <= '0;
      sb_reg        <= '0;
      bus.ex_valid  <= 1'b0;
      bus.fwd_a_sel <= '0;
      bus.fwd_b_sel <= '0;
    end else begin
      sb_valid      <= {sb_valid[DEPTH-2:0], load};
      sb_wb_en      <= {sb_wb_en[DEPTH-2:0], load & bus.id_wb_en};
      sb_load       <= {sb_load[DEPTH-2:0],  load & bus.id_is_load};
      sb_reg        <= {sb_reg[DEPTH-2:0],   bus.id_wb_reg};
      bus.ex_valid  <= load;
      bus.fwd_a_sel <= load ? res_a.sel : '0;
      bus.fwd_b_sel <= load ? res_b.sel : '0;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (bus.stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
